// File: rtl/yadge_uio_tx_if.sv
// Byte-source and pad-side signals of the uio transmitter, grouped for port connection.
// tx_par exists only when YADGE_TX_PARITY_EN is defined.
interface yadge_uio_tx_if #(
    parameter int DEPTH = 4
);
    logic [7:0]             wr_data;
    logic                   wr_valid;
    logic                   wr_ready;
    logic [7:0]             tx_data;
    logic [7:0]             tx_oe;
    logic                   tx_req;
    logic                   tx_ack;
    logic                   busy;
    logic [$clog2(DEPTH):0] level;
    logic                   timeout_err;
    logic                   err_clr;
`ifdef YADGE_TX_PARITY_EN
    logic                   tx_par;
`endif

    modport master (
        input  wr_data, wr_valid, tx_ack, err_clr,
        output wr_ready, tx_data, tx_oe, tx_req, busy, level, timeout_err
`ifdef YADGE_TX_PARITY_EN
        , output tx_par
`endif
    );

    modport slave (
        output wr_data, wr_valid, tx_ack, err_clr,
        input  wr_ready, tx_data, tx_oe, tx_req, busy, level, timeout_err
`ifdef YADGE_TX_PARITY_EN
        , input tx_par
`endif
    );
endinterface

// File: rtl/yadge_uio_tx.sv
// uio byte transmitter: FIFO feeding a four-phase req/ack sequencer with per-phase timeout.
// Optional even-parity output tx_par is enabled by defining YADGE_TX_PARITY_EN.
module yadge_uio_tx #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    yadge_uio_tx_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [15:0]   TIMER_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, REQ, REL} state_t;

    state_t          state_reg, state_next;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [LW-1:0]   level_reg, level_next;
    logic [15:0]     timer_reg, timer_next;
    logic            wr_ready_reg, busy_reg, timeout_err_reg, tx_req_reg;
    logic [7:0]      tx_data_reg, tx_oe_reg;
    logic            ack_meta_reg, ack_s_reg;
    logic            push, pop, timeout_hit, load;
`ifdef YADGE_TX_PARITY_EN
    logic            tx_par_reg;
`endif

    // wr_ready is registered, so a full FIFO refuses a push even on a pop cycle
    assign push = bus.wr_valid && wr_ready_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta_reg <= 1'b0;
            ack_s_reg    <= 1'b0;
        end else begin
            ack_meta_reg <= bus.tx_ack;
            ack_s_reg    <= ack_meta_reg;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pop         = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE:  if (level_reg != '0) state_next = SETUP;
            SETUP: if (!ack_s_reg) state_next = REQ;
            REQ:   if (ack_s_reg) state_next = REL;
            REL: begin
                if (!ack_s_reg) begin
                    pop        = 1'b1;
                    state_next = (level_reg > LW'(1)) ? SETUP : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // A phase that has lasted TIMEOUT cycles drops its byte and releases the bus
        if (state_reg != IDLE && state_next == state_reg && timer_reg == TIMER_LAST) begin
            timeout_hit = 1'b1;
            pop         = 1'b1;
            state_next  = IDLE;
        end
        if (state_next != state_reg || state_reg == IDLE) timer_next = '0;
        else                                              timer_next = timer_reg + 16'd1;

        rd_ptr_next = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
        load        = (state_next == SETUP) && (state_reg != SETUP);

        level_next = level_reg;
        if (push && !pop)      level_next = level_reg + LW'(1);
        else if (!push && pop) level_next = level_reg - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= bus.wr_data;
    end

    // Head byte is read as the sequencer enters SETUP, so the pads see it a cycle before tx_req
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_reg <= 8'h00;
`ifdef YADGE_TX_PARITY_EN
            tx_par_reg  <= 1'b0;
`endif
        end else if (load) begin
            tx_data_reg <= mem[rd_ptr_next];
`ifdef YADGE_TX_PARITY_EN
            tx_par_reg  <= ^mem[rd_ptr_next];
`endif
        end else if (state_next == IDLE) begin
            tx_data_reg <= 8'h00;
`ifdef YADGE_TX_PARITY_EN
            tx_par_reg  <= 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            timer_reg       <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            level_reg       <= '0;
            wr_ready_reg    <= 1'b1;
            busy_reg        <= 1'b0;
            tx_oe_reg       <= 8'h00;
            tx_req_reg      <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            rd_ptr_reg   <= rd_ptr_next;
            level_reg    <= level_next;
            wr_ready_reg <= (level_next != FULL_LEVEL);
            busy_reg     <= (state_next != IDLE) || (level_next != '0);
            tx_oe_reg    <= (state_next != IDLE) ? 8'hFF : 8'h00;
            tx_req_reg   <= (state_next == REQ);
            if (timeout_hit)      timeout_err_reg <= 1'b1;
            else if (bus.err_clr) timeout_err_reg <= 1'b0;
        end
    end

    assign bus.wr_ready    = wr_ready_reg;
    assign bus.tx_data     = tx_data_reg;
    assign bus.tx_oe       = tx_oe_reg;
    assign bus.tx_req      = tx_req_reg;
    assign bus.busy        = busy_reg;
    assign bus.level       = level_reg;
    assign bus.timeout_err = timeout_err_reg;
`ifdef YADGE_TX_PARITY_EN
    assign bus.tx_par      = tx_par_reg;
`endif
endmodule
